// File: rtl/id_stage_param.sv
// -----------------------------------------------------------------------------
// id_stage_param
//
// Instruction-decode stage between instruction fetch and the execute FIFO.
// Decodes the opcode into a class, reads two operands from an internal
// register file with same-cycle write-back bypass, tracks pending
// destinations in a per-register scoreboard to stall RAW/WAW hazards, and
// hands decoded packets downstream through a single-entry valid/ready
// output register.
//
// Ports
//   clk            clock, all state on rising edge
//   reset          asynchronous, active-high reset
//   instr_valid    fetch offers an instruction
//   instr_ready    stage accepts the offered instruction this cycle (comb.)
//   instruction    {opcode, rd, rs1, rs2, unused...} MSB-first
//   wb_valid       write-back strobe
//   wb_addr        write-back register index (>= NUM_REGS is ignored)
//   wb_data        write-back value
//   out_valid      decoded packet available
//   out_ready      execute FIFO can take the packet
//   out_data       {op_b, op_a, opcode, rd}
//   busy_mask      scoreboard pending bits, one per register
//   illegal_count  saturating count of dropped illegal opcodes
//   stall_count    saturating count of cycles stalled on a hazard
// -----------------------------------------------------------------------------
module id_stage_param #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4,
    parameter int OPC_W    = 5,
    parameter int INSTR_W  = 32,
    parameter int CNT_W    = 8,
    localparam int PKT_W   = 2*DATA_W + OPC_W + ADDR_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [INSTR_W-1:0]  instruction,
    input  logic                wb_valid,
    input  logic [ADDR_W-1:0]   wb_addr,
    input  logic [DATA_W-1:0]   wb_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PKT_W-1:0]    out_data,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic [CNT_W-1:0]    illegal_count,
    output logic [CNT_W-1:0]    stall_count
);

    // Opcode set
    localparam logic [OPC_W-1:0] OP_MOV            = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_ADD            = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_SUB            = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_AND            = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_OR             = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_NOT            = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_MULT           = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_DIV            = OPC_W'(7);
    localparam logic [OPC_W-1:0] OP_CMP            = OPC_W'(8);
    localparam logic [OPC_W-1:0] OP_OB_CHECK       = OPC_W'(9);
    localparam logic [OPC_W-1:0] OP_VELOCITY_GUARD = OPC_W'(10);
    localparam logic [OPC_W-1:0] OP_MOVE_LEFT      = OPC_W'(11);
    localparam logic [OPC_W-1:0] OP_MOVE_RIGHT     = OPC_W'(12);
    localparam logic [OPC_W-1:0] OP_STOP           = OPC_W'(13);
    localparam logic [OPC_W-1:0] OP_CONTINUE       = OPC_W'(14);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // W: reads rs1/rs2, writes rd. R: reads only. M: no register traffic.
    typedef enum logic [1:0] {CLS_W, CLS_R, CLS_M, CLS_ILL} op_class_e;

    // ---------------------------------------------------------------- fields
    logic [OPC_W-1:0]  opcode;
    logic [ADDR_W-1:0] rd, rs1, rs2;

    assign opcode = instruction[INSTR_W-1 -: OPC_W];
    assign rd     = instruction[INSTR_W-OPC_W-1 -: ADDR_W];
    assign rs1    = instruction[INSTR_W-OPC_W-ADDR_W-1 -: ADDR_W];
    assign rs2    = instruction[INSTR_W-OPC_W-2*ADDR_W-1 -: ADDR_W];

    generate
        if (INSTR_W > OPC_W + 3*ADDR_W) begin : g_pad
            logic unused_instr_bits;
            assign unused_instr_bits = ^instruction[INSTR_W-OPC_W-3*ADDR_W-1:0];
        end
    endgenerate

    // ----------------------------------------------------------------- state
    logic [DATA_W-1:0]   rf_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                out_valid_q, out_valid_d;
    logic [PKT_W-1:0]    out_data_q, out_data_d;
    logic [CNT_W-1:0]    illegal_cnt_q, illegal_cnt_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

    // ---------------------------------------------------------------- decode
    op_class_e op_class;

    always_comb begin
        case (opcode)
            OP_MOV, OP_ADD, OP_SUB, OP_AND,
            OP_OR, OP_NOT, OP_MULT, OP_DIV:                 op_class = CLS_W;
            OP_CMP, OP_OB_CHECK, OP_VELOCITY_GUARD:         op_class = CLS_R;
            OP_MOVE_LEFT, OP_MOVE_RIGHT, OP_STOP,
            OP_CONTINUE:                                    op_class = CLS_M;
            default:                                        op_class = CLS_ILL;
        endcase
    end

    // One-hot views of the register indices; out-of-range indices map to all
    // zeros, so they neither hit the scoreboard nor write the register file.
    logic [NUM_REGS-1:0] rd_oh, rs1_oh, rs2_oh, wb_oh;

    always_comb begin
        rd_oh  = '0;
        rs1_oh = '0;
        rs2_oh = '0;
        wb_oh  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_oh[i]  = (rd  == ADDR_W'(i));
            rs1_oh[i] = (rs1 == ADDR_W'(i));
            rs2_oh[i] = (rs2 == ADDR_W'(i));
            wb_oh[i]  = wb_valid && (wb_addr == ADDR_W'(i));
        end
    end

    // ------------------------------------------------------- operand read
    logic [DATA_W-1:0] rf_a, rf_b, op_a, op_b;

    always_comb begin
        // NOTE: every variable gets a default before the loop so no path
        // leaves it unassigned; otherwise synthesis would infer a latch.
        rf_a = '0;
        rf_b = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rs1_oh[i]) rf_a = rf_q[i];
            if (rs2_oh[i]) rf_b = rf_q[i];
        end
    end

    // Same-cycle write-back bypass: a value being written now is the value read.
    assign op_a = (wb_valid && wb_addr == rs1) ? wb_data : rf_a;
    assign op_b = (wb_valid && wb_addr == rs2) ? wb_data : rf_b;

    // --------------------------------------------------------------- hazard
    // A register being written back this cycle is no longer pending, which
    // lets a stalled instruction go in the very cycle its source arrives.
    logic [NUM_REGS-1:0] eff_busy;
    logic                src_hazard, dst_hazard, hazard;

    assign eff_busy   = busy_q & ~wb_oh;
    assign src_hazard = |(eff_busy & (rs1_oh | rs2_oh));
    assign dst_hazard = |(eff_busy & rd_oh);

    always_comb begin
        case (op_class)
            CLS_W:   hazard = src_hazard | dst_hazard;
            CLS_R:   hazard = src_hazard;
            default: hazard = 1'b0;
        endcase
    end

    assign instr_ready = !hazard && (!out_valid_q || out_ready);

    // ----------------------------------------------------------- next state
    logic accept, legal_accept;

    assign accept       = instr_valid && instr_ready;
    assign legal_accept = accept && (op_class != CLS_ILL);

    always_comb begin
        out_valid_d   = legal_accept || (out_valid_q && !out_ready);
        out_data_d    = out_data_q;
        busy_d        = busy_q & ~wb_oh;
        illegal_cnt_d = illegal_cnt_q;
        stall_cnt_d   = stall_cnt_q;

        if (legal_accept) begin
            if (op_class == CLS_M)
                out_data_d = {{(2*DATA_W){1'b0}}, opcode, rd};
            else
                out_data_d = {op_b, op_a, opcode, rd};
        end

        // Applied after the write-back clear so a same-edge set wins.
        if (legal_accept && op_class == CLS_W)
            busy_d = busy_d | rd_oh;

        if (accept && op_class == CLS_ILL && illegal_cnt_q != CNT_MAX)
            illegal_cnt_d = illegal_cnt_q + CNT_W'(1);

        if (instr_valid && hazard && stall_cnt_q != CNT_MAX)
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the register file is architecturally defined as zero
            // after reset, so it is built from resettable flops rather than
            // a RAM macro with undefined contents.
            for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
            busy_q        <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            illegal_cnt_q <= '0;
            stall_cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            for (int i = 0; i < NUM_REGS; i++)
                if (wb_oh[i]) rf_q[i] <= wb_data;
            busy_q        <= busy_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            illegal_cnt_q <= illegal_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign busy_mask     = busy_q;
    assign illegal_count = illegal_cnt_q;
    assign stall_count   = stall_cnt_q;

endmodule

// File: doc/id_stage_param.md
# id_stage_param

Parametrised, handshaked instruction-decode stage for the async CPU. It sits between instruction fetch and the execute FIFO. It decodes each instruction against the `defines.v` opcode set and reads operands from an internal register file with write-back bypass. A per-register scoreboard stalls read-after-write and write-after-write hazards, and a single-entry output register with valid/ready flow control drives the execute FIFO.

## Interface
- DATA_W, 16, register/operand width
- NUM_REGS, 16, register count
- ADDR_W, 4, register address width (2^ADDR_W ≥ NUM_REGS)
- OPC_W, 5, opcode width
- INSTR_W, 32, instruction width (≥ OPC_W+3*ADDR_W)
- PKT_W derived = 2*DATA_W+OPC_W+ADDR_W; CNT_W, 8, status counter width

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clock clk
- instr_valid  in  1  fetch offers an instruction
- instr_ready  out  1  stage accepts instruction this cycle
- instruction  in  INSTR_W  opcode=[INSTR_W-1 -: OPC_W], then rd, rs1, rs2 (ADDR_W each, MSB-first)
- wb_valid  in  1  write-back strobe
- wb_addr  in  ADDR_W  write-back register
- wb_data  in  DATA_W  write-back value
- out_valid  out  1  packet available
- out_ready  in  1  execute FIFO can take packet
- out_data  out  PKT_W  {op_b, op_a, opcode, rd}
- busy_mask  out  NUM_REGS  scoreboard pending bits
- illegal_count  out  CNT_W  saturating count of dropped illegal opcodes
- stall_count  out  CNT_W  saturating count of hazard-stall cycles

## Operation
- Opcode classes:
  - W (reads rs1/rs2, writes rd): MOV ADD SUB AND OR NOT MULT DIV.
  - R (reads rs1/rs2, no rd write): CMP OB_CHECK VELOCITY_GUARD.
  - M (no reads, no write): MOVE_LEFT MOVE_RIGHT STOP CONTINUE. Operands are forced to 0.
  - Any other opcode is illegal.
- Operand read: op_a=RF[rs1] and op_b=RF[rs2]. If wb_valid and wb_addr matches the source in the same cycle, the operand is wb_data (bypass).
- Write-back: RF[wb_addr] is written with wb_data at the edge. The same edge clears busy[wb_addr]. wb_addr ≥ NUM_REGS is ignored.
- Effective busy: eff_busy = busy & ~(wb_valid ? onehot(wb_addr) : 0).
- Hazard:
  - W: stall if eff_busy[rs1], eff_busy[rs2] or eff_busy[rd].
  - R: stall if eff_busy[rs1] or eff_busy[rs2].
  - M and illegal opcodes never stall.
- instr_ready = !hazard && (!out_valid || out_ready).
- Accept = instr_valid && instr_ready. On accept:
  - Legal opcode: load out_data and set out_valid=1. For class W, set busy[rd]. If the same edge also clears busy[rd], the set wins.
  - Illegal opcode: the instruction is consumed and no packet is produced. illegal_count increments, saturating at 2^CNT_W-1. out_valid is cleared if out_ready drained the held packet.
- If out_valid && out_ready with no accept, out_valid becomes 0 and out_data holds its last value.
- stall_count increments on each cycle with instr_valid && hazard, saturating.
- Reset (async, any time):
  - RF, busy_mask, out_data, illegal_count and stall_count → 0.
  - out_valid → 0.
  - An in-flight packet is discarded.
  - instr_ready is combinational and becomes 1 after reset.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N shows as out_valid/out_data after edge N.
- Full throughput is one instruction per cycle while out_ready=1 and no hazards.
- While out_valid && !out_ready, out_data is stable and instr_ready=0.
- Bypass is combinational, with zero-cycle write-to-read.
- A stall on a source register is released in the same cycle wb_valid targets that register.
- All outputs are registered except instr_ready.

## Test plan
- Reset: assert reset mid-stream with out_valid=1 → out_valid=0, out_data=0, busy_mask=0, both counters 0 immediately (asynchronously, with no clock edge).
- ADD bypass and back-to-back: RF[2]=5, RF[3]=7, then issue ADD rd=1, rs1=2, rs2=3 with the same-cycle wb (addr 3, data 9) → next cycle out_data={16'd9,16'd5,OP_ADD,4'd1}, busy_mask[1]=1.
- RAW stall: ADD rd=1, then SUB rs1=1 → instr_ready=0 and stall_count increments each cycle. wb (addr 1, data 0x00AA) → SUB accepted that cycle with op_a=0x00AA, busy_mask[1]=0.
- Backpressure: hold out_ready=0 for 4 cycles with instr_valid=1 → out_data unchanged, instr_ready=0. Release → the next packet appears one cycle later.
- Class M and illegal:
  - MOVE_LEFT with rs1 busy → no stall, operands 0, busy unchanged.
  - An undefined opcode → no out_valid; illegal_count goes 0→1.
  - 300 illegal opcodes → illegal_count=255.
- WAW with simultaneous set/clear: MOV rd=4 pending. A second MOV rd=4 is offered in the same cycle as wb addr 4 → accepted, busy_mask[4] remains 1.
